pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage 64-bit pipeline. It drives the write-enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles three events: load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory accesses. It also keeps a wait-timeout watchdog and two saturating performance counters.

## Interface
- WAIT_MAX, 15: maximum consecutive data-memory wait cycles before `mem_fault` is set.
- CNT_W, 32: width of the performance counters.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch).
- ex_memread  in  1  ID/EX MemRead (the instruction in EX is a load).
- ex_rd  in  5  ID/EX destination register.
- mem_branch, mem_zero, mem_invert  in  1 each  EX/MEM Branch, Zero and addermuxselect; `mem_invert`=1 means branch-on-not-equal.
- mem_access  in  1  EX/MEM MemRead | MemWrite.
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_write, pc_sel  out  1 each  PC enable; `pc_sel`=1 selects the branch target (EM_Adder2Out).
- ifid_en, idex_en, exmem_en  out  1 each  register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous bubble insert (clears control bits).
- mem_fault  out  1  sticky watchdog flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

## Operation
- Derived signals:
  - `taken` = mem_branch & (mem_zero ^ mem_invert).
  - `load_use` = ex_memread & (ex_rd≠0) & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
  - `mem_stall` = mem_access & ~dmem_ready.
- Default (no event): pc_write, ifid_en, idex_en and exmem_en are 1; all flushes are 0; pc_sel is 0.
- Event priority is mem_stall > taken > load_use.
- mem_stall:
  - pc_write, ifid_en, idex_en and exmem_en are 0.
  - memwb_flush is 1.
  - pc_sel is 0.
- taken:
  - pc_sel and pc_write are 1.
  - ifid_flush, idex_flush and exmem_flush are 1, squashing three younger instructions.
  - A coincident load_use is ignored because it belongs to a squashed instruction.
- load_use:
  - pc_write and ifid_en are 0.
  - idex_flush is 1, inserting one bubble.
  - The hazard clears itself the next cycle.
- The FSM has two states: RUN and MEM_WAIT.
  - RUN → MEM_WAIT when mem_stall; wait_cnt←1.
  - In MEM_WAIT, while mem_stall holds, wait_cnt increments, saturating at WAIT_MAX.
  - When wait_cnt==WAIT_MAX and mem_stall holds, mem_fault←1. It is sticky and cleared only by reset.
  - MEM_WAIT → RUN when dmem_ready; wait_cnt←0.
- Control outputs are combinational from the inputs. The FSM only tracks wait duration and fault.
- Counters:
  - stall_cnt increments on every cycle with mem_stall or (load_use & ~taken).
  - flush_cnt increments on every cycle with taken & ~mem_stall.
  - Both counters saturate at all-ones.

## Timing
- Control outputs have zero-cycle latency and act at the same clock edge on which the pipeline registers capture.
- A load-use hazard costs exactly 1 stall cycle.
- A taken branch costs 3 flushed slots; the redirected PC is captured at the same edge.
- A memory wait of N cycles freezes stages IF–MEM for N cycles. The edge with dmem_ready=1 advances normally.
- While reset is low, and asynchronously upon its assertion:
  - state=RUN, wait_cnt=0, mem_fault=0, stall_cnt=0, flush_cnt=0.
  - All enables, flushes and pc_sel are forced to 0.
- Reset asserted mid-wait aborts the wait. After release the controller is in RUN with counters at 0.
- mem_stall and taken asserted together: the stall wins and the branch is held in EX/MEM. It is acted on at the cycle dmem_ready rises; that edge performs the flush and counts it once.
- ex_rd==0 never stalls.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum {RUN, MEM_WAIT};
  - the default values of WAIT_MAX and CNT_W;
  - the flush/enable bundle struct.
- Sub-module `load_use_detect` is purely combinational. Its inputs are the ex/id register fields; its output is `load_use`.
- The top level contains the priority logic, the FSM, the wait counter and the perf counters.

## Test plan
- Load-use: `ld x5` in EX (ex_memread=1, ex_rd=5) with `add x6,x5,x7` in ID → for exactly 1 cycle pc_write=0, ifid_en=0, idex_flush=1; stall_cnt=1.
- rd=x0 load with id_rs1=0 → no stall; all enables stay 1.
- Branch taken: beq with mem_zero=1 and mem_invert=0 → pc_sel=1 and three flushes for 1 cycle; flush_cnt=1. The same branch with mem_invert=1 → no flush.
- Memory wait: mem_access=1, dmem_ready=0 for 4 cycles → 4 frozen cycles with memwb_flush=1, then normal advance; stall_cnt=4; mem_fault=0.
- Timeout: dmem_ready held 0 for 20 cycles with WAIT_MAX=15 → mem_fault=1 from the 16th wait cycle and still 1 after dmem_ready rises. Pulsing reset low clears mem_fault, the FSM and the counters asynchronously.
- Simultaneous events: taken together with load_use → flush only, no stall count. taken together with mem_stall → freeze first, then flush on the dmem_ready cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states, default sizes
// and the packed bundle of enables/flushes driven into the five pipeline registers.
package pipe_ctrl_pkg;

    localparam int WAIT_MAX_DEF = 15;
    localparam int CNT_W_DEF    = 32;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic pc_sel;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF = '{default: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline fields observed by the controller and the
// enable/flush/status signals it returns. The controller side is the slave modport.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             mem_branch;
    logic             mem_zero;
    logic             mem_invert;
    logic             mem_access;
    logic             dmem_ready;

    logic             pc_write;
    logic             pc_sel;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
               mem_branch, mem_zero, mem_invert, mem_access, dmem_ready,
        input  pc_write, pc_sel, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               mem_fault, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd,
               mem_branch, mem_zero, mem_invert, mem_access, dmem_ready,
        output pc_write, pc_sel, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               mem_fault, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: the load in EX writes a register the ID
// instruction reads. Zero latency; x0 is never a hazard.
module load_use_detect (
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs2,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rd,
    output logic       o_load_use
);

    logic w_rd_nonzero;
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_rd_nonzero = (i_ex_rd != 5'd0);
    assign w_hit_rs1    = (i_ex_rd == i_id_rs1);
    assign w_hit_rs2    = i_id_uses_rs2 && (i_ex_rd == i_id_rs2);
    assign o_load_use   = i_ex_memread && w_rd_nonzero && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: combinational priority
// mem_stall > taken > load_use, plus a memory-wait watchdog and perf counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int WCW = $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] W_MAX = WCW'(WAIT_MAX);

    logic             w_taken;
    logic             w_load_use;
    logic             w_mem_stall;
    logic             w_stall_inc;
    logic             w_flush_inc;
    ctrl_t            w_ctrl;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WCW-1:0]   r_wait_cnt;
    logic [WCW-1:0]   w_wait_nxt;
    logic             r_fault;
    logic             w_fault_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    load_use_detect u_lu (
        .i_id_rs1      (bus.id_rs1),
        .i_id_rs2      (bus.id_rs2),
        .i_id_uses_rs2 (bus.id_uses_rs2),
        .i_ex_memread  (bus.ex_memread),
        .i_ex_rd       (bus.ex_rd),
        .o_load_use    (w_load_use)
    );

    assign w_taken     = bus.mem_branch && (bus.mem_zero ^ bus.mem_invert);
    assign w_mem_stall = bus.mem_access && !bus.dmem_ready;

    // A branch held in EX/MEM behind a stall is acted on (and counted) only
    // on the cycle the access completes, so taken is masked by the stall.
    assign w_stall_inc = w_mem_stall || (w_load_use && !w_taken);
    assign w_flush_inc = w_taken && !w_mem_stall;

    always_comb begin
        w_ctrl          = CTRL_OFF;
        w_ctrl.pc_write = 1'b1;
        w_ctrl.ifid_en  = 1'b1;
        w_ctrl.idex_en  = 1'b1;
        w_ctrl.exmem_en = 1'b1;
        if (!reset) begin
            w_ctrl = CTRL_OFF;
        end else if (w_mem_stall) begin
            w_ctrl             = CTRL_OFF;
            w_ctrl.memwb_flush = 1'b1;
        end else if (w_taken) begin
            w_ctrl.pc_sel      = 1'b1;
            w_ctrl.ifid_flush  = 1'b1;
            w_ctrl.idex_flush  = 1'b1;
            w_ctrl.exmem_flush = 1'b1;
        end else if (w_load_use) begin
            w_ctrl.pc_write   = 1'b0;
            w_ctrl.ifid_en    = 1'b0;
            w_ctrl.idex_flush = 1'b1;
        end
    end

    assign bus.pc_write    = w_ctrl.pc_write;
    assign bus.pc_sel      = w_ctrl.pc_sel;
    assign bus.ifid_en     = w_ctrl.ifid_en;
    assign bus.idex_en     = w_ctrl.idex_en;
    assign bus.exmem_en    = w_ctrl.exmem_en;
    assign bus.ifid_flush  = w_ctrl.ifid_flush;
    assign bus.idex_flush  = w_ctrl.idex_flush;
    assign bus.exmem_flush = w_ctrl.exmem_flush;
    assign bus.memwb_flush = w_ctrl.memwb_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    // Leaving MEM_WAIT on any cycle without a stall also covers an access
    // withdrawn before completion, so the watchdog never runs on stale state.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_fault_nxt = r_fault;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (!w_mem_stall) begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt == W_MAX) begin
                    w_fault_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.mem_fault = r_fault;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule
